// File: rtl/ddr_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : ddr_pkg
// Brief   : Chart ROM, lane encoding and hit-window defaults for the playfield
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
package ddr_pkg;

    localparam int NUM_NOTES  = 26;
    localparam int IDX_W      = 5;
    localparam int POS_W      = 14;
    localparam int SPEED_DEF  = 2;
    localparam int BASE_X_DEF = 400;
    localparam int HIT_LO_DEF = 380;
    localparam int HIT_HI_DEF = 420;
    localparam int END_Y_DEF  = 1930;

    typedef enum logic [1:0] {
        LANE0 = 2'd0,
        LANE1 = 2'd1,
        LANE2 = 2'd2,
        LANE3 = 2'd3
    } lane_e;

    typedef struct packed {
        lane_e       lane;
        logic [10:0] offset;
    } chart_entry_t;

    localparam logic [1:0] CHART_LANES [NUM_NOTES] = '{
        2'd1, 2'd2, 2'd0, 2'd2, 2'd1, 2'd1, 2'd1,
        2'd2, 2'd2, 2'd2, 2'd1, 2'd3, 2'd3,
        2'd1, 2'd2, 2'd0, 2'd2, 2'd1, 2'd1, 2'd1,
        2'd1, 2'd2, 2'd2, 2'd1, 2'd2, 2'd0
    };

    // Offsets come in four phrases of 50-pixel steps separated by rests.
    function automatic logic [10:0] chart_offset(input logic [IDX_W-1:0] idx);
        logic [10:0]      base;
        logic [IDX_W-1:0] first;
        if (idx < 5'd7) begin
            base  = 11'd0;
            first = 5'd0;
        end else if (idx < 5'd13) begin
            base  = 11'd400;
            first = 5'd7;
        end else if (idx < 5'd20) begin
            base  = 11'd800;
            first = 5'd13;
        end else begin
            base  = 11'd1200;
            first = 5'd20;
        end
        return base + 11'(idx - first) * 11'd50;
    endfunction

    function automatic chart_entry_t chart_entry(input logic [IDX_W-1:0] idx);
        chart_entry_t e;
        e.offset = chart_offset(idx);
        e.lane   = LANE0;
        if (idx < 5'(NUM_NOTES)) begin
            e.lane = lane_e'(CHART_LANES[idx]);
        end
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/note_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : note_sequencer_if
// Brief   : Button/frame inputs and renderer/score outputs of the sequencer
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
interface note_sequencer_if;
    import ddr_pkg::*;

    logic             frame_tick;
    logic [4:0]       BTNS;
    logic [POS_W-1:0] ball_x;
    logic [POS_W-1:0] ball_y;
    logic [IDX_W-1:0] note_idx;
    logic [7:0]       hits;
    logic [7:0]       misses;
    logic             playing;
    logic             done;

    modport master (
        input  frame_tick, BTNS,
        output ball_x, ball_y, note_idx, hits, misses, playing, done
    );

    modport slave (
        output frame_tick, BTNS,
        input  ball_x, ball_y, note_idx, hits, misses, playing, done
    );

endinterface
`default_nettype wire

// File: rtl/btn_edge.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : btn_edge
// Brief   : Registered rising-edge detector for the debounced buttons
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module btn_edge #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] btns,
    output logic [WIDTH-1:0] edges
);

    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_edge;

    // History clears to all-ones so a button held through reset must be released first.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_prev <= '1;
            r_edge <= '0;
        end else begin
            r_prev <= btns;
            r_edge <= btns & ~r_prev;
        end
    end

    assign edges = r_edge;

endmodule
`default_nettype wire

// File: rtl/note_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : note_sequencer
// Brief   : Scrolls the note chart per frame, judges presses, keeps the score
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module note_sequencer
    import ddr_pkg::*;
#(
    parameter int SPEED  = SPEED_DEF,
    parameter int BASE_X = BASE_X_DEF,
    parameter int HIT_LO = HIT_LO_DEF,
    parameter int HIT_HI = HIT_HI_DEF,
    parameter int END_Y  = END_Y_DEF
) (
    input  logic             clk,
    input  logic             clr,
    note_sequencer_if.master bus
);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_play  = 2'd1;
    localparam logic [1:0] c_pause = 2'd2;
    localparam logic [1:0] c_done  = 2'd3;

    localparam logic [POS_W-1:0] c_speed  = POS_W'(SPEED);
    localparam logic [POS_W-1:0] c_base_x = POS_W'(BASE_X);
    localparam logic [POS_W-1:0] c_hit_lo = POS_W'(HIT_LO);
    localparam logic [POS_W-1:0] c_hit_hi = POS_W'(HIT_HI);
    localparam logic [POS_W-1:0] c_end_y  = POS_W'(END_Y);

    logic [1:0]       r_state;
    logic [POS_W-1:0] r_ball_x;
    logic [POS_W-1:0] r_ball_y;
    logic [IDX_W-1:0] r_note_idx;
    logic [7:0]       r_hits;
    logic [7:0]       r_misses;
    logic             r_playing;
    logic             r_done;

    logic [4:0]       w_edge;
    logic             w_start;
    logic [3:0]       w_lane_edge;
    chart_entry_t     w_note;
    logic [POS_W-1:0] w_offset;
    logic [POS_W-1:0] w_note_y;
    logic             w_judge;
    logic             w_reached;
    logic             w_in_win;
    logic             w_passed;
    logic             w_correct;
    logic             w_wrong;

    btn_edge #(.WIDTH(5)) u_btn_edge (
        .clk   (clk),
        .clr   (clr),
        .btns  (bus.BTNS),
        .edges (w_edge)
    );

    // Button wiring is not in lane order: lane0..3 sit on BTNS[2], [4], [1], [3].
    assign w_start     = w_edge[0];
    assign w_lane_edge = {w_edge[3], w_edge[1], w_edge[4], w_edge[2]};

    assign w_note    = chart_entry(r_note_idx);
    assign w_offset  = {3'b000, w_note.offset};
    assign w_note_y  = r_ball_y - w_offset;
    assign w_judge   = (r_state == c_play) && (r_note_idx < IDX_W'(NUM_NOTES));
    assign w_reached = (r_ball_y >= w_offset);
    assign w_in_win  = w_judge && w_reached && (w_note_y >= c_hit_lo) && (w_note_y <= c_hit_hi);
    assign w_passed  = w_judge && w_reached && (w_note_y > c_hit_hi);
    assign w_correct = |(w_lane_edge & (4'b0001 << w_note.lane));
    assign w_wrong   = (|w_lane_edge) && !w_correct;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state    <= c_idle;
            r_ball_x   <= c_base_x;
            r_ball_y   <= '0;
            r_note_idx <= '0;
            r_hits     <= '0;
            r_misses   <= '0;
            r_playing  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_ball_x  <= c_base_x;
            r_playing <= (r_state == c_play);
            r_done    <= (r_state == c_done);

            case (r_state)
                c_idle: begin
                    r_ball_y <= '0;
                    if (w_start) r_state <= c_play;
                end
                c_play: begin
                    if (w_start) begin
                        r_state <= c_pause;
                    end else if (r_ball_y >= c_end_y) begin
                        r_state <= c_done;
                    end else if (bus.frame_tick) begin
                        r_ball_y <= r_ball_y + c_speed;
                    end
                end
                c_pause: begin
                    if (w_start) r_state <= c_play;
                end
                c_done: begin
                    if (w_start) begin
                        r_state    <= c_idle;
                        r_ball_y   <= '0;
                        r_note_idx <= '0;
                        r_hits     <= '0;
                        r_misses   <= '0;
                    end
                end
                default: r_state <= c_idle;
            endcase

            // A correct press beats everything; a passed note beats a stray press.
            if (w_in_win && w_correct) begin
                r_hits     <= (r_hits == 8'hFF) ? r_hits : r_hits + 8'd1;
                r_note_idx <= r_note_idx + 5'd1;
            end else if (w_passed) begin
                r_misses   <= (r_misses == 8'hFF) ? r_misses : r_misses + 8'd1;
                r_note_idx <= r_note_idx + 5'd1;
            end else if (w_in_win && w_wrong) begin
                r_misses   <= (r_misses == 8'hFF) ? r_misses : r_misses + 8'd1;
            end
        end
    end

    assign bus.ball_x   = r_ball_x;
    assign bus.ball_y   = r_ball_y;
    assign bus.note_idx = r_note_idx;
    assign bus.hits     = r_hits;
    assign bus.misses   = r_misses;
    assign bus.playing  = r_playing;
    assign bus.done     = r_done;

endmodule
`default_nettype wire
